// File: rtl/seg_pkg.sv
// Shared definitions for the paged 7-segment driver: segment bit positions,
// the hex glyph table and the page-count helpers.
package seg_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;
    localparam int unsigned SEG_W = SEG_G + 1;

    // Index n holds the glyph for hex digit n (entry 0 is the rightmost element).
    localparam logic [15:0][SEG_W-1:0] HEX7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int unsigned calc_num_pages(input int unsigned value_w,
                                                   input int unsigned num_digits);
        return (value_w + 4 * num_digits - 1) / (4 * num_digits);
    endfunction

    function automatic int unsigned calc_page_w(input int unsigned value_w,
                                                input int unsigned num_digits);
        int unsigned np;
        np = calc_num_pages(value_w, num_digits);
        return (np <= 1) ? 1 : $clog2(np);
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble to active-high 7-segment glyph decoder.
module hex7seg_decode
    import seg_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = HEX7_TABLE[nibble];
    end

endmodule

// File: rtl/seg_pager.sv
// Paged, multiplexed hex display driver with a one-entry holding register
// and a shadow that only reloads at page wrap. Optional leading-zero blanking
// is enabled by defining SEG_PAGER_BLANK_EN.
module seg_pager
    import seg_pkg::*;
#(
    parameter int unsigned VALUE_W    = 32,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 12000,
    parameter int unsigned PAGE_DIV   = 16777216,
    parameter int unsigned PAGE_W     = calc_page_w(VALUE_W, NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  value_valid,
    output logic                  value_ready,
    output logic [SEG_W-1:0]      segment,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [PAGE_W-1:0]     page,
    output logic                  colon
);

    localparam int unsigned NUM_PAGES  = calc_num_pages(VALUE_W, NUM_DIGITS);
    localparam int unsigned SHADOW_W   = NUM_PAGES * 4 * NUM_DIGITS;
    localparam int unsigned NIB_TOTAL  = NUM_PAGES * NUM_DIGITS;
    localparam int unsigned IDX_W      = (NIB_TOTAL <= 1) ? 1 : $clog2(NIB_TOTAL);
    localparam int unsigned DIG_W      = (NUM_DIGITS <= 1) ? 1 : $clog2(NUM_DIGITS);
    localparam int unsigned SCAN_W     = $clog2(SCAN_DIV);
    localparam int unsigned PAGE_CNT_W = $clog2(PAGE_DIV);

    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [PAGE_CNT_W-1:0] page_cnt_q, page_cnt_d;
    logic [DIG_W-1:0]      digit_q, digit_d;
    logic [PAGE_W-1:0]     page_q, page_d;
    logic [SHADOW_W-1:0]   shadow_q, shadow_d;
    logic [VALUE_W-1:0]    hold_q, hold_d;
    logic                  value_ready_q, value_ready_d;
    logic [SEG_W-1:0]      segment_q, segment_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic                  colon_q, colon_d;

    logic                  scan_term;
    logic                  page_term;
    logic                  page_wrap;
    logic [IDX_W-1:0]      nib_idx;
    logic [3:0]            nibble;
    logic [SEG_W-1:0]      dec_seg;

    hex7seg_decode u_dec (
        .nibble (nibble),
        .seg_c  (dec_seg)
    );

    // Counters, handshake/shadow update and the registered display outputs.
    always_comb begin
        scan_term     = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        page_term     = (page_cnt_q == PAGE_CNT_W'(PAGE_DIV - 1));
        page_wrap     = page_term && (page_q == PAGE_W'(NUM_PAGES - 1));

        scan_cnt_d    = scan_term ? '0 : scan_cnt_q + SCAN_W'(1);
        page_cnt_d    = page_term ? '0 : page_cnt_q + PAGE_CNT_W'(1);
        digit_d       = digit_q;
        page_d        = page_q;
        shadow_d      = shadow_q;
        hold_d        = hold_q;
        value_ready_d = value_ready_q;

        if (scan_term) begin
            digit_d = (digit_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_q + DIG_W'(1);
        end
        if (page_term) begin
            page_d = page_wrap ? '0 : page_q + PAGE_W'(1);
        end

        // Full holding register drains only at page wrap; ready=0 blocks accepts meanwhile.
        if (page_wrap && !value_ready_q) begin
            shadow_d      = SHADOW_W'(hold_q);
            value_ready_d = 1'b1;
        end else if (value_ready_q && value_valid) begin
            hold_d        = value;
            value_ready_d = 1'b0;
        end

        nib_idx = IDX_W'(page_q) * IDX_W'(NUM_DIGITS) + IDX_W'(digit_q);
        nibble  = 4'(shadow_q >> {nib_idx, 2'b00});

`ifdef SEG_PAGER_BLANK_EN
        // Blank when this nibble and everything above it in the shadow is zero.
        if ((nib_idx != '0) && ((shadow_q >> {nib_idx, 2'b00}) == '0)) begin
            segment_d = '0;
        end else begin
            segment_d = dec_seg;
        end
`else
        segment_d = dec_seg;
`endif

        digit_sel_d = NUM_DIGITS'(1) << digit_q;
        colon_d     = (page_q != '0);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            scan_cnt_q    <= '0;
            page_cnt_q    <= '0;
            digit_q       <= '0;
            page_q        <= '0;
            shadow_q      <= '0;
            hold_q        <= '0;
            value_ready_q <= 1'b1;
            segment_q     <= '0;
            digit_sel_q   <= '0;
            colon_q       <= 1'b0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            page_cnt_q    <= page_cnt_d;
            digit_q       <= digit_d;
            page_q        <= page_d;
            shadow_q      <= shadow_d;
            hold_q        <= hold_d;
            value_ready_q <= value_ready_d;
            segment_q     <= segment_d;
            digit_sel_q   <= digit_sel_d;
            colon_q       <= colon_d;
        end
    end

    assign value_ready = value_ready_q;
    assign segment     = segment_q;
    assign digit_sel   = digit_sel_q;
    assign page        = page_q;
    assign colon       = colon_q;

endmodule

// File: tb/tb_seg_pager.sv
// Scoreboard bench for seg_pager: a cycle-count reference model queues the
// expected outputs per clock; an independent monitor pops and compares.
module tb_seg_pager;

    localparam int ND = 4;
    localparam int S  = 4;
    localparam int P  = 64;
    localparam int NP = 2;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] sel;
        logic       pg;
        logic       colon;
        logic       ready;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] value = '0;
    logic        value_valid = 1'b0;
    logic        value_ready;
    logic [6:0]  segment;
    logic [3:0]  digit_sel;
    logic [0:0]  page;
    logic        colon;

    int vectors = 0;
    int miscompares = 0;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state: edges since reset release, shadow and holding entry.
    int          m_n = 0;
    logic [31:0] m_shadow = '0;
    logic [31:0] m_hold = '0;
    logic        m_full = 1'b0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_pager #(
        .VALUE_W    (32),
        .NUM_DIGITS (ND),
        .SCAN_DIV   (S),
        .PAGE_DIV   (P)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .segment     (segment),
        .digit_sel   (digit_sel),
        .page        (page),
        .colon       (colon)
    );

    always #5 clk = ~clk;

    // Drive one clock of stimulus and queue what the outputs must be after that edge.
    task automatic step(input logic rn, input logic v, input logic [31:0] val, output logic acc);
        exp_t e;
        int   pg;
        int   dg;
        int   k;
        logic [31:0] above;
        resetn      = rn;
        value_valid = v;
        value       = val;
        acc         = 1'b0;
        if (!rn) begin
            e = '{7'h00, 4'h0, 1'b0, 1'b0, 1'b1};
            m_n = 0;
            m_shadow = '0;
            m_full = 1'b0;
        end else begin
            pg = (m_n / P) % NP;
            dg = (m_n / S) % ND;
            k  = pg * ND + dg;
            above = m_shadow >> (4 * k);
            e.seg = hex_tab[4'(above & 32'hF)];
`ifdef SEG_PAGER_BLANK_EN
            if (k != 0 && above == 0) e.seg = 7'h00;
`endif
            e.sel   = 4'(1 << dg);
            e.colon = (pg != 0);
            if (m_full && ((m_n + 1) % (P * NP) == 0)) begin
                m_shadow = m_hold;
                m_full   = 1'b0;
            end else if (!m_full && v) begin
                m_hold = val;
                m_full = 1'b1;
                acc    = 1'b1;
            end
            m_n = m_n + 1;
            e.pg    = (((m_n / P) % NP) != 0);
            e.ready = !m_full;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, $urandom, a);
    endtask

    // Hold valid until the model accepts; bounded so a stuck handshake cannot hang.
    task automatic send(input logic [31:0] val);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 600 && !a; i++) step(1'b1, 1'b1, val, a);
        if (!a) begin
            miscompares++;
            $display("FAIL send_timeout: value %08h not accepted, required acceptance within 600 cycles", val);
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: vector %0d got %0h required %0h", name, vectors, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            chk("segment",     int'(segment),     int'(mon_e.seg));
            chk("digit_sel",   int'(digit_sel),   int'(mon_e.sel));
            chk("page",        int'(page),        int'(mon_e.pg));
            chk("colon",       int'(colon),       int'(mon_e.colon));
            chk("value_ready", int'(value_ready), int'(mon_e.ready));
        end
    end

    initial begin
        logic a;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, a);

        // Idle: zeros displayed, digit walk and page/colon alternation.
        idle(300);

        send(32'h1234ABCD);
        idle(300);

        // Second value waits in valid until the wrap frees the holding register.
        send(32'h11111111);
        send(32'h22222222);
        idle(300);

        for (int i = 0; i < 2000; i++) begin
            step(1'b1, ($urandom_range(0, 7) == 0), $urandom, a);
        end

        // Fill holding right after a wrap, then reset mid-page.
        while (m_full) idle(1);
        while (((m_n + 1) % (P * NP)) != 0) idle(1);
        idle(1);
        send(32'hDEADBEEF);
        idle(20);
        step(1'b0, 1'b0, '0, a);
        idle(200);

        send(32'h00000012);
        idle(300);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_pager.md
# seg_pager

Paged, multiplexed 7-segment hex display driver for values wider than the physical display. It splits a VALUE_W-bit value into pages of NUM_DIGITS nibbles each, cycles through the pages on a timer, and raises a colon indicator on upper pages. Values arrive through a valid/ready handshake and are double-buffered, so a page sequence never shows a torn value. It sits between compute blocks (cordic results, counters) and the PMOD 7-segment pins in the top level.

## Interface
- VALUE_W, 32: width of displayed value
- NUM_DIGITS, 4: physical digits (≥1)
- SCAN_DIV, 12000: clk cycles per digit slot (≥2)
- PAGE_DIV, 16777216: clk cycles per page (≥ SCAN_DIV)
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
- value  in  VALUE_W  value to display
- value_valid  in  1  value present
- value_ready  out  1  holding register empty; transfer when valid && ready
- segment  out  7  active-high segments; bit0=a … bit6=g
- digit_sel  out  NUM_DIGITS  one-hot active-high; bit i = digit i (digit 0 rightmost)
- page  out  PAGE_W  current page index; PAGE_W = max(1, clog2(NUM_PAGES))
- colon  out  1  high when page != 0

## Operation
- NUM_PAGES = ceil(VALUE_W / (4·NUM_DIGITS)). The shadow is zero-extended to NUM_PAGES·4·NUM_DIGITS bits.
- Page p, digit i shows shadow nibble [4(p·NUM_DIGITS+i) +: 4]. Page 0 holds the least-significant nibbles.
- Holding register: one entry. Accepts on valid && ready, then ready drops. While ready=0, valid has no effect.
- Scan counter: 0..SCAN_DIV-1. At the terminal count, the digit index advances and wraps NUM_DIGITS-1→0.
- Page counter: 0..PAGE_DIV-1, independent of the scan counter. At the terminal count, page advances mod NUM_PAGES.
- Page wrap is the cycle where the page counter hits terminal with page=NUM_PAGES-1. If the holding register is full at page wrap: shadow ← holding, holding empties, and ready=1 next cycle.
- With NUM_PAGES=1, page wrap is every page-counter terminal; colon stays 0.
- Hex encoding is standard: 0→7'h3F, 1→7'h06, … 9→7'h6F, A→7'h77, b→7'h7C, C→7'h39, d→7'h5E, E→7'h79, F→7'h71.

## Timing
- Reset values: segment=0, digit_sel=0, page=0, colon=0, value_ready=1. Shadow=0, holding empty, all counters 0.
- segment, digit_sel and colon are registered, one cycle behind the internal digit/page state. The first cycle after reset release shows digit_sel=1, segment=7'h3F.
- Digit change: digit_sel and segment update in the same cycle, with no cross-digit ghost cycle.
- A new value is visible starting from page 0 in the cycle after the page wrap that loads it, plus the 1-cycle output register.
- Accept and shadow load cannot coincide, because ready=0 while the holding register is full.
- Reset asserted mid-operation returns every output and counter to its reset value on the next edge. Any pending holding value is discarded.

## Configuration
- SEG_PAGER_BLANK_EN defined: leading-zero blanking. A digit outputs segment=0 when it and every more-significant nibble of the whole shadow are zero. digit_sel still cycles. Nibble 0 (page 0, digit 0) is never blanked.
- Undefined: all digits are always driven, including leading zeros.

## Structure
- Shared package seg_pkg holds the hex-to-segment constant table, segment bit-position localparams, and the NUM_PAGES/PAGE_W computation function.
- Sub-module hex7seg_decode: a combinational nibble→7-bit segment decoder, instantiated once.

## Test plan
All scenarios use VALUE_W=32, NUM_DIGITS=4, SCAN_DIV=4, PAGE_DIV=64.
- Reset, value never sent → digit_sel walks 1,2,4,8 every 4 cycles; segment=7'h3F; colon toggles every 64 cycles; page alternates 0/1.
- Send 32'h1234ABCD → accepted; after the next page wrap, page 0 shows digits D,C,B,A (digit0..3) with colon=0, and page 1 shows 4,3,2,1 with colon=1.
- Send 32'h11111111, then hold valid with 32'h22222222 → ready=0 until the wrap; the display never mixes 1s and 2s within one page sequence.
- Assert resetn=0 mid-page with the holding register full → next cycle all outputs are at reset values, ready=1, display shows zeros.
- With SEG_PAGER_BLANK_EN, send 32'h00000012 → page 0 shows digit0=7'h5B, digit1=7'h06, digits 2–3 segment=0; page 1 is all blank.
- Scan/page terminal coincidence: check that the cycle where both counters hit terminal advances digit and page together, with no skipped or doubled digit slot.
